mips_cpu_div_ctrl: RTL and testbench

Sequencer for DIV/DIVU that owns the HI/LO register pair and the internal unsigned divider. It accepts a divide request from the execute stage, converts signed operands to magnitudes, starts the divider, applies sign correction, writes HI (remainder) and LO (quotient), and asserts a stall while busy. It also services MTHI/MTLO writes and supplies HI/LO to MFHI/MFLO.

---
 rtl/mips_cpu_div_ctrl_pkg.sv | 22 ++
 rtl/mips_cpu_div_ctrl_if.sv | 28 ++
 rtl/mips_cpu_divideru.sv | 103 ++++++++++
 rtl/mips_cpu_div_ctrl.sv | 137 +++++++++++++
 tb/tb_mips_cpu_div_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_div_ctrl_pkg.sv
// Shared types and helpers for the DIV/DIVU sequencer and its unsigned divider.
package mips_cpu_div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } div_state_t;

    // Two's-complement negate when neg is set, pass through otherwise.
    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
        if (neg) begin
            cond_neg = ~v + {{(DIV_W-1){1'b0}}, 1'b1};
        end else begin
            cond_neg = v;
        end
    endfunction

endpackage

// File: rtl/mips_cpu_div_ctrl_if.sv
// Execute-stage request, MTHI/MTLO write and HI/LO read bundle of the divide sequencer.
interface mips_cpu_div_ctrl_if;
    import mips_cpu_div_pkg::*;

    logic             op_start;
    logic             op_signed;
    logic [DIV_W-1:0] op_a;
    logic [DIV_W-1:0] op_b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [DIV_W-1:0] wdata;
    logic             busy;
    logic             op_done;
    logic [DIV_W-1:0] hi;
    logic [DIV_W-1:0] lo;

    modport master (
        output op_start, op_signed, op_a, op_b, flush, hi_we, lo_we, wdata,
        input  busy, op_done, hi, lo
    );

    modport slave (
        input  op_start, op_signed, op_a, op_b, flush, hi_we, lo_we, wdata,
        output busy, op_done, hi, lo
    );

endinterface

// File: rtl/mips_cpu_divideru.sv
// Unsigned 32/32 restoring divider: 32 iterations after start, or an immediate
// result when the dividend is zero or smaller than the divisor.
module mips_cpu_divideru
    import mips_cpu_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0] divisor,
    output logic             done,
    output logic             dbz,
    output logic [DIV_W-1:0] quotient,
    output logic [DIV_W-1:0] remainder
);

    logic [DIV_W-1:0] quo_q, quo_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DIV_W-1:0] dvs_q, dvs_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;
    logic [DIV_W:0]   shifted_s;
    logic [DIV_W:0]   trial_s;

    // Next-state: load on start, otherwise one shift/subtract step per cycle while counting.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;
        shifted_s = {rem_q, quo_q[DIV_W-1]};
        trial_s   = shifted_s - {1'b0, dvs_q};
        if (start) begin
            dvs_d = divisor;
            if (divisor == {DIV_W{1'b0}}) begin
                quo_d  = {DIV_W{1'b1}};
                rem_d  = dividend;
                cnt_d  = 6'd0;
                dbz_d  = 1'b1;
                done_d = 1'b1;
            end else if ((dividend == {DIV_W{1'b0}}) || (divisor > dividend)) begin
                quo_d  = {DIV_W{1'b0}};
                rem_d  = dividend;
                cnt_d  = 6'd0;
                dbz_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                quo_d = dividend;
                rem_d = {DIV_W{1'b0}};
                cnt_d = 6'd32;
                dbz_d = 1'b0;
            end
        end else if (cnt_q != 6'd0) begin
            cnt_d  = cnt_q - 6'd1;
            done_d = (cnt_q == 6'd1);
            if (!trial_s[DIV_W]) begin
                rem_d = trial_s[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[DIV_W-1:0];
                quo_d = {quo_q[DIV_W-2:0], 1'b0};
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with async reset and synchronous abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q  <= {DIV_W{1'b0}};
            rem_q  <= {DIV_W{1'b0}};
            dvs_q  <= {DIV_W{1'b0}};
            cnt_q  <= 6'd0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else if (srst) begin
            quo_q  <= {DIV_W{1'b0}};
            rem_q  <= {DIV_W{1'b0}};
            dvs_q  <= {DIV_W{1'b0}};
            cnt_q  <= 6'd0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            dbz_q  <= dbz_d;
        end
    end

    assign done      = done_q;
    assign dbz       = dbz_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mips_cpu_div_ctrl.sv
// DIV/DIVU sequencer: owns HI/LO, converts signed operands to magnitudes,
// drives the unsigned divider and sign-corrects its results.
module mips_cpu_div_ctrl
    import mips_cpu_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    mips_cpu_div_ctrl_if.slave   bus
);

    div_state_t       state_q, state_d;
    logic [DIV_W-1:0] hi_q, hi_d;
    logic [DIV_W-1:0] lo_q, lo_d;
    logic [DIV_W-1:0] mag_a_q, mag_a_d;
    logic [DIV_W-1:0] mag_b_q, mag_b_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             busy_q;
    logic             op_done_q;
    logic             flush_pulse_s;
    logic             div_start_s;
    logic             div_done_s;
    logic             div_dbz_s;
    logic [DIV_W-1:0] div_quo_s;
    logic [DIV_W-1:0] div_rem_s;

    assign flush_pulse_s = bus.flush && (state_q != IDLE);
    assign div_start_s   = (state_q == ISSUE);

    mips_cpu_divideru u_divu (
        .clk       (clk),
        .rst_n     (reset_n),
        .srst      (flush_pulse_s),
        .start     (div_start_s),
        .dividend  (mag_a_q),
        .divisor   (mag_b_q),
        .done      (div_done_s),
        .dbz       (div_dbz_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // Next-state and HI/LO update logic; a flush overrides everything outside IDLE.
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (bus.hi_we) begin
                    hi_d = bus.wdata;
                end else begin
                    hi_d = hi_q;
                end
                if (bus.lo_we) begin
                    lo_d = bus.wdata;
                end else begin
                    lo_d = lo_q;
                end
                if (bus.op_start) begin
                    neg_quo_d = bus.op_signed & (bus.op_a[DIV_W-1] ^ bus.op_b[DIV_W-1]);
                    neg_rem_d = bus.op_signed & bus.op_a[DIV_W-1];
                    mag_a_d   = cond_neg(bus.op_a, bus.op_signed & bus.op_a[DIV_W-1]);
                    mag_b_d   = cond_neg(bus.op_b, bus.op_signed & bus.op_b[DIV_W-1]);
                    if (bus.op_b == {DIV_W{1'b0}}) begin
                        state_d = RETIRE;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // Zero divisors never reach the divider, so dbz only screens a stale result.
                if (div_done_s && !div_dbz_s) begin
                    lo_d    = cond_neg(div_quo_s, neg_quo_q);
                    hi_d    = cond_neg(div_rem_s, neg_rem_q);
                    state_d = RETIRE;
                end else begin
                    state_d = WAIT;
                end
            end
            RETIRE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush_pulse_s) begin
            state_d = IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end else begin
            state_d = state_d;
        end
    end

    // State, HI/LO and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            hi_q      <= {DIV_W{1'b0}};
            lo_q      <= {DIV_W{1'b0}};
            mag_a_q   <= {DIV_W{1'b0}};
            mag_b_q   <= {DIV_W{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy_q    <= 1'b0;
            op_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mag_a_q   <= mag_a_d;
            mag_b_q   <= mag_b_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            busy_q    <= (state_d != IDLE);
            op_done_q <= (state_d == RETIRE);
        end
    end

    assign bus.busy    = busy_q;
    assign bus.op_done = op_done_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: tb/tb_mips_cpu_div_ctrl.sv
// Directed plus randomized bench for mips_cpu_div_ctrl against an arithmetic reference model.
module tb_mips_cpu_div_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mips_cpu_div_ctrl_if bus ();

    mips_cpu_div_ctrl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] hi_m     = 32'd0;
    logic [31:0] lo_m     = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference: quotient/remainder by plain 64-bit arithmetic, latency from operand magnitudes.
    task automatic ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r, output int lat);
        longint sa, sb, ma, mb, tq, tr;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'(a);
            sb = longint'(b);
        end
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 32'd0) begin
            q   = lo_m;
            r   = hi_m;
            lat = 0;
        end else begin
            tq  = sa / sb;
            tr  = sa % sb;
            q   = tq[31:0];
            r   = tr[31:0];
            lat = ((ma == 0) || (mb > ma)) ? 2 : 34;
        end
    endtask

    task automatic mt_write(input logic hwe, input logic lwe, input logic [31:0] d);
        bus.hi_we = hwe;
        bus.lo_we = lwe;
        bus.wdata = d;
        step();
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (hwe) hi_m = d;
        if (lwe) lo_m = d;
        chk("mt_hi", bus.hi, hi_m);
        chk("mt_lo", bus.lo, lo_m);
    endtask

    task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic with_mthi, input logic [31:0] mt_data, input logic interfere);
        logic [31:0] q, r;
        int          lat, n;
        logic        busy_ok, started;
        if (with_mthi) hi_m = mt_data;
        ref_div(s, a, b, q, r, lat);
        bus.op_signed = s;
        bus.op_a      = a;
        bus.op_b      = b;
        bus.op_start  = 1'b1;
        bus.hi_we     = with_mthi;
        bus.wdata     = mt_data;
        step();
        bus.op_start = 1'b0;
        bus.hi_we    = 1'b0;
        started      = dut.div_start_s;
        chk({tag, "_busy0"}, {31'd0, bus.busy}, 32'd1);
        if (with_mthi) chk({tag, "_mthi"}, bus.hi, mt_data);
        n       = 0;
        busy_ok = 1'b1;
        while ((bus.op_done !== 1'b1) && (n < 60)) begin
            if (interfere && (n == 5)) begin
                bus.op_start = 1'b1;
                bus.op_a     = 32'd50;
                bus.op_b     = 32'd5;
                bus.hi_we    = 1'b1;
                bus.lo_we    = 1'b1;
                bus.wdata    = 32'hDEAD_BEEF;
            end
            step();
            n++;
            bus.op_start = 1'b0;
            bus.hi_we    = 1'b0;
            bus.lo_we    = 1'b0;
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_latency"}, 32'(n), 32'(lat));
        chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
        chk({tag, "_div_start"}, {31'd0, started}, {31'd0, (b != 32'd0)});
        lo_m = q;
        hi_m = r;
        chk({tag, "_lo"}, bus.lo, lo_m);
        chk({tag, "_hi"}, bus.hi, hi_m);
        step();
        chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_done_pulse"}, {31'd0, bus.op_done}, 32'd0);
        step();
        chk({tag, "_no_restart"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        logic        seen_done;
        logic [31:0] ra, rb;
        logic        rs;
        int          sel;

        bus.op_start  = 1'b0;
        bus.op_signed = 1'b0;
        bus.op_a      = 32'd0;
        bus.op_b      = 32'd0;
        bus.flush     = 1'b0;
        bus.hi_we     = 1'b0;
        bus.lo_we     = 1'b0;
        bus.wdata     = 32'd0;
        reset_n       = 1'b0;
        step();
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.op_done}, 32'd0);
        reset_n = 1'b1;
        step();

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 32'd0, 1'b0);
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'd0, 1'b0);
        run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd0, 1'b0);
        run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);
        run_div("divu_5_9", 1'b0, 32'd5, 32'd9, 1'b0, 32'd0, 1'b0);
        run_div("divu_eq", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 1'b0);

        mt_write(1'b1, 1'b0, 32'h0000_AAAA);
        mt_write(1'b0, 1'b1, 32'h0000_5555);
        run_div("divu_dbz", 1'b0, 32'd5, 32'd0, 1'b0, 32'd0, 1'b0);
        run_div("mthi_with_div", 1'b0, 32'd1000, 32'd7, 1'b1, 32'h1234_5678, 1'b0);
        run_div("busy_ignore", 1'b0, 32'hFFFF_0000, 32'h0000_1234, 1'b0, 32'd0, 1'b1);

        // Flush mid-divide: accepted at edge 0, flushed at edge 10.
        bus.op_signed = 1'b0;
        bus.op_a      = 32'd1000;
        bus.op_b      = 32'd3;
        bus.op_start  = 1'b1;
        step();
        bus.op_start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_hi", bus.hi, hi_m);
        chk("flush_lo", bus.lo, lo_m);
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.op_done === 1'b1) seen_done = 1'b1;
        end
        chk("flush_no_done", {31'd0, seen_done}, 32'd0);
        chk("flush_hi_late", bus.hi, hi_m);
        chk("flush_lo_late", bus.lo, lo_m);
        run_div("divu_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0);

        // Randomized operands of mixed shapes.
        for (int k = 0; k < 24; k++) begin
            sel = $urandom_range(0, 3);
            rs  = 1'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) begin
                ra = 32'($urandom_range(0, 500));
                rb = 32'($urandom_range(1, 40));
            end else if (sel == 1) begin
                rb = rb >> $urandom_range(4, 28);
                if (rb == 32'd0) rb = 32'd3;
            end else if (sel == 2) begin
                rb = 32'd0;
            end else begin
                ra = ra >> 8;
            end
            if (rs && ($urandom_range(0, 1) == 1)) rb = -rb;
            run_div("rand", rs, ra, rb, 1'($urandom_range(0, 1)), $urandom, 1'b0);
        end

        // Async reset in the middle of a long divide.
        run_div("pre_reset", 1'b0, 32'd77, 32'd5, 1'b0, 32'd0, 1'b0);
        bus.op_signed = 1'b0;
        bus.op_a      = 32'h1234_5678;
        bus.op_b      = 32'd3;
        bus.op_start  = 1'b1;
        step();
        bus.op_start = 1'b0;
        for (int i = 0; i < 19; i++) step();
        reset_n = 1'b0;
        #1;
        hi_m = 32'd0;
        lo_m = 32'd0;
        chk("arst_hi", bus.hi, hi_m);
        chk("arst_lo", bus.lo, lo_m);
        chk("arst_busy", {31'd0, bus.busy}, 32'd0);
        chk("arst_done", {31'd0, bus.op_done}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        run_div("post_reset", 1'b1, 32'hFFFF_FF9C, 32'd7, 1'b0, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
